// File: rtl/enc_pkg.sv
// Shared fixed-point definitions for the encoder layers: defaults, FSM state
// encoding and saturating add/multiply helpers evaluated on a 64-bit carrier.
package enc_pkg;

    localparam int ENC_BITSIZE = 20;
    localparam int ENC_FRAC    = 10;
    localparam int EXT_W       = 64;

    localparam logic signed [ENC_BITSIZE-1:0] SAT_MAX = {1'b0, {(ENC_BITSIZE-1){1'b1}}};
    localparam logic signed [ENC_BITSIZE-1:0] SAT_MIN = {1'b1, {(ENC_BITSIZE-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MAC   = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } enc_state_t;

    // Clamp a wide value into the signed range of a bits-wide word.
    function automatic logic signed [EXT_W-1:0] sat_clip(input logic signed [EXT_W-1:0] v,
                                                         input int bits);
        logic signed [EXT_W-1:0] hi_s;
        logic signed [EXT_W-1:0] lo_s;
        hi_s = (64'sd1 <<< (bits - 1)) - 64'sd1;
        lo_s = -(64'sd1 <<< (bits - 1));
        if (v > hi_s) begin
            return hi_s;
        end else if (v < lo_s) begin
            return lo_s;
        end else begin
            return v;
        end
    endfunction

    function automatic logic signed [EXT_W-1:0] sat_add(input logic signed [EXT_W-1:0] a,
                                                        input logic signed [EXT_W-1:0] b,
                                                        input int bits);
        return sat_clip(a + b, bits);
    endfunction

    // Operands are sign-extended words of at most 32 bits, so the product is exact.
    function automatic logic signed [EXT_W-1:0] sat_mul(input logic signed [EXT_W-1:0] a,
                                                        input logic signed [EXT_W-1:0] b,
                                                        input int bits,
                                                        input int frac);
        logic signed [EXT_W-1:0] p_s;
        p_s = a * b;
        return sat_clip(p_s >>> frac, bits);
    endfunction

endpackage

// File: rtl/fixed_point_mac_sat.sv
// Combinational saturating multiply-accumulate: sum = sat(acc + sat((a*b) >>> FRAC)).
module fixed_point_mac_sat
    import enc_pkg::*;
#(
    parameter int BITSIZE = ENC_BITSIZE,
    parameter int FRAC    = ENC_FRAC
) (
    input  logic signed [BITSIZE-1:0] acc,
    input  logic signed [BITSIZE-1:0] a,
    input  logic signed [BITSIZE-1:0] b,
    output logic signed [BITSIZE-1:0] sum
);

    logic signed [EXT_W-1:0] acc_ext_s;
    logic signed [EXT_W-1:0] a_ext_s;
    logic signed [EXT_W-1:0] b_ext_s;
    logic signed [EXT_W-1:0] prod_s;
    logic signed [EXT_W-1:0] sum_ext_s;

    assign acc_ext_s = {{(EXT_W-BITSIZE){acc[BITSIZE-1]}}, acc};
    assign a_ext_s   = {{(EXT_W-BITSIZE){a[BITSIZE-1]}}, a};
    assign b_ext_s   = {{(EXT_W-BITSIZE){b[BITSIZE-1]}}, b};
    assign prod_s    = sat_mul(a_ext_s, b_ext_s, BITSIZE, FRAC);
    assign sum_ext_s = sat_add(acc_ext_s, prod_s, BITSIZE);
    assign sum       = sum_ext_s[BITSIZE-1:0];

endmodule

// File: rtl/enc_1_layer.sv
// First encoder layer: six neurons sharing one saturating MAC under an FSM.
// Define ENC1_LEAKY_RELU_EN to replace ReLU with a 1/8-slope leaky ReLU.
module enc_1_layer
    import enc_pkg::*;
#(
    parameter int BITSIZE = ENC_BITSIZE,
    parameter int FRAC    = ENC_FRAC,
    parameter int IN_DIM  = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [BITSIZE*IN_DIM-1:0]     x,
    input  logic [BITSIZE*6*IN_DIM-1:0]   w,
    input  logic [BITSIZE*6-1:0]          b,
    output logic [BITSIZE*6-1:0]          y,
    output logic                          busy,
    output logic                          done,
    output logic                          valid
);

    localparam int KW = (IN_DIM > 1) ? $clog2(IN_DIM) : 1;

    enc_state_t                  state_r;
    logic [2:0]                  n_r;
    logic [KW-1:0]               k_r;
    logic signed [BITSIZE-1:0]   acc_r;
    logic [BITSIZE*IN_DIM-1:0]   x_reg_r;
    logic [BITSIZE*6-1:0]        y_r;
    logic                        busy_r;
    logic                        done_r;
    logic                        valid_r;

    logic signed [BITSIZE-1:0]   x_k_s;
    logic signed [BITSIZE-1:0]   w_nk_s;
    logic signed [BITSIZE-1:0]   b_next_s;
    logic signed [BITSIZE-1:0]   mac_sum_s;
    logic signed [BITSIZE-1:0]   act_s;

    // Select the current MAC operands and the bias that seeds the next neuron.
    always_comb begin
        x_k_s  = x_reg_r[BITSIZE*int'(k_r) +: BITSIZE];
        w_nk_s = w[BITSIZE*(int'(n_r)*IN_DIM + int'(k_r)) +: BITSIZE];
        if (n_r < 3'd5) begin
            b_next_s = b[BITSIZE*(int'(n_r) + 1) +: BITSIZE];
        end else begin
            b_next_s = b[BITSIZE-1:0];
        end
    end

    fixed_point_mac_sat #(
        .BITSIZE (BITSIZE),
        .FRAC    (FRAC)
    ) u_mac (
        .acc (acc_r),
        .a   (x_k_s),
        .b   (w_nk_s),
        .sum (mac_sum_s)
    );

    // Activation applied to the finished accumulator of the current neuron.
    always_comb begin
        act_s = acc_r;
`ifdef ENC1_LEAKY_RELU_EN
        if (acc_r[BITSIZE-1]) begin
            act_s = acc_r >>> 3;
        end else begin
            act_s = acc_r;
        end
`else
        if (acc_r[BITSIZE-1]) begin
            act_s = {BITSIZE{1'b0}};
        end else begin
            act_s = acc_r;
        end
`endif
    end

    // Sequencer: one MAC step per cycle, one write per neuron, then a done cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            n_r     <= 3'd0;
            k_r     <= {KW{1'b0}};
            acc_r   <= {BITSIZE{1'b0}};
            x_reg_r <= {(BITSIZE*IN_DIM){1'b0}};
            y_r     <= {(BITSIZE*6){1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            valid_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        x_reg_r <= x;
                        n_r     <= 3'd0;
                        k_r     <= {KW{1'b0}};
                        acc_r   <= b[BITSIZE-1:0];
                        busy_r  <= 1'b1;
                        valid_r <= 1'b0;
                        state_r <= ST_MAC;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_MAC: begin
                    acc_r <= mac_sum_s;
                    if (k_r == KW'(IN_DIM - 1)) begin
                        state_r <= ST_WRITE;
                    end else begin
                        k_r <= k_r + KW'(1);
                    end
                end
                ST_WRITE: begin
                    y_r[BITSIZE*int'(n_r) +: BITSIZE] <= act_s;
                    if (n_r == 3'd5) begin
                        done_r  <= 1'b1;
                        valid_r <= 1'b1;
                        busy_r  <= 1'b0;
                        state_r <= ST_DONE;
                    end else begin
                        n_r     <= n_r + 3'd1;
                        k_r     <= {KW{1'b0}};
                        acc_r   <= b_next_s;
                        state_r <= ST_MAC;
                    end
                end
                ST_DONE: begin
                    done_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign y     = y_r;
    assign busy  = busy_r;
    assign done  = done_r;
    assign valid = valid_r;

endmodule

// File: doc/enc_1_layer.md
Name: enc_1_layer

Overview:
- First encoder layer: computes 6 neurons, y[n] = act(b[n] + sum_k x[k]*w[n][k]), over an IN_DIM-element input vector.
- Uses one shared multiplier/adder, time-multiplexed under an FSM.
- Its packed 6-element output drives the 6-element input vector of the downstream single-neuron encoder stage (enc_2).
- start/done handshake; the output vector is held stable with a valid level until the next start.

Parameters:
- BITSIZE, 20, word width; signed two's complement fixed point.
- FRAC, 10, fractional bits (Q9.10 at default; 1.0 = 0x00400).
- IN_DIM, 4, input vector length (>=1).

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous active-high reset.
- start  input  1  one-cycle request; sampled only in IDLE.
- x  input  BITSIZE*IN_DIM  input vector; element k at [BITSIZE*k +: BITSIZE].
- w  input  BITSIZE*6*IN_DIM  weights; w[n][k] at [BITSIZE*(n*IN_DIM+k) +: BITSIZE]; must be static while busy.
- b  input  BITSIZE*6  biases; b[n] at [BITSIZE*n +: BITSIZE]; must be static while busy.
- y  output  BITSIZE*6  output vector; y[n] at [BITSIZE*n +: BITSIZE].
- busy  output  1  high from the cycle after start is accepted until DONE.
- done  output  1  one-cycle pulse when all 6 outputs are written.
- valid  output  1  level; y is complete and stable.

Behaviour:
- Reset (sync, clk edge with reset=1): state=IDLE; y=0, busy=0, done=0, valid=0; n, k, acc and x_reg all 0. Reset mid-computation aborts with no partial results retained.
- IDLE:
  - start=1 latches x into x_reg, sets n=0, k=0, acc=b[0], busy=1, valid=0, and moves to MAC.
  - start=0 stays in IDLE.
- MAC: acc <= sat(acc + mul(x_reg[k], w[n][k])).
  - If k==IN_DIM-1 go to WRITE, else k++.
- WRITE: y[n] <= act(acc).
  - If n==5 go to DONE.
  - Else n++, k=0, acc=b[n+1], go to MAC.
- DONE: done=1 for exactly this cycle; valid=1, busy=0; next state IDLE.
- Latency: done is high 6*(IN_DIM+1) cycles after the start-sampling edge (30 at IN_DIM=4).
- y[n] updates only in its own WRITE. Other elements hold their previous values until overwritten; valid=0 marks y as incomplete.
- start in MAC, WRITE or DONE is ignored, with no queuing. start in the IDLE cycle right after DONE is accepted (back-to-back runs).
- x may change after start is accepted; x_reg isolates it.
- mul(a,b): full 2*BITSIZE signed product, arithmetic shift right by FRAC (floor), saturate to [-2^(BITSIZE-1), 2^(BITSIZE-1)-1].
- Add: BITSIZE+1-bit signed sum, saturated to the same range.
- act: ReLU (negative -> 0, otherwise pass) unless the optional feature is enabled.

Optional Feature:
- Macro ENC1_LEAKY_RELU_EN.
- Defined: negative acc maps to acc >>> 3 (arithmetic, slope 1/8); non-negative passes unchanged.
- Undefined: plain ReLU, negative -> 0.
- Ports and timing are identical in both builds.

Decomposition:
- Shared package enc_pkg:
  - FRAC default.
  - State encoding: IDLE, MAC, WRITE, DONE (2-bit).
  - sat_add and sat_mul functions, shared with enc_2 and later layers.
  - SAT_MAX/SAT_MIN constants derived from BITSIZE.
- Sub-module fixed_point_mac_sat: combinational acc + a*b with the saturation rules above. It is instantiated once; the FSM and output register live in enc_1_layer.

Test Plan:
- Basic run: x all 1.0 (0x00400), w all 0.5 (0x00200), b=0, start 1 cycle -> done exactly 30 cycles later. All y[n]=0x00800 (2.0), valid=1, busy low after done.
- Bias and negative path: w[2][*]=-1.0 (0xFFC00), b[2]=0, b[0]=0.25 (0x00100) -> y[0]=0x00900 and y[2]=0 (ReLU). With ENC1_LEAKY_RELU_EN, y[2]=0xFFE00 (-0.5).
- Saturation: x[0]=256.0 (0x40000), w[0][0]=2.0 (0x00800), other w=0, b=0 -> y[0]=0x7FFFF. With w[0][0]=-2.0, y[0]=0 (ReLU), or 0xF0000 with leaky.
- Start while busy: second start pulses at cycles 5 and 29 -> a single done at cycle 30, results unchanged. A start the cycle after done is accepted, with the next done 30 cycles later.
- Reset mid-op: reset at cycle 12 -> next cycle y=0, valid=0, busy=0, no done pulse. A fresh start then completes with the correct basic-run values.
- x changes after start: toggle x to 0 one cycle after start -> y identical to the basic run (latched x_reg).
